// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register file for the conv accelerator: RW config registers, a read-only
// status word at reg 1 and a self-clearing start pulse on reg 0 bit 0.
module axi_lite_reg_slave #(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_NUM_REGS         = 8
) (
  input  logic                                       S_AXI_ACLK,
  input  logic                                       S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
  input  logic [2:0]                                 S_AXI_AWPROT,
  input  logic                                       S_AXI_AWVALID,
  output logic                                       S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
  input  logic                                       S_AXI_WVALID,
  output logic                                       S_AXI_WREADY,
  output logic [1:0]                                 S_AXI_BRESP,
  output logic                                       S_AXI_BVALID,
  input  logic                                       S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
  input  logic [2:0]                                 S_AXI_ARPROT,
  input  logic                                       S_AXI_ARVALID,
  output logic                                       S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]              S_AXI_RDATA,
  output logic [1:0]                                 S_AXI_RRESP,
  output logic                                       S_AXI_RVALID,
  input  logic                                       S_AXI_RREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]              i_status,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   o_regs,
  output logic                                       o_start
);

  localparam int unsigned DATA_W   = C_S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned IDX_W    = $clog2(C_NUM_REGS);
  localparam int unsigned ADDR_LSB = 2;
  localparam int unsigned HI_LSB   = ADDR_LSB + IDX_W;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_RESP} r_state_t;

  w_state_t w_state_q, w_state_n;
  r_state_t r_state_q, r_state_n;

  logic [DATA_W-1:0] regs_q [C_NUM_REGS];
  logic              awready_q, bvalid_q, start_q, arready_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q;

  logic              wr_en_c, wr_oor_c, wr_store_c, start_c;
  logic [IDX_W-1:0]  wr_idx_c;
  logic [DATA_W-1:0] wr_merged_c;
  logic              rd_en_c, rd_oor_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [DATA_W-1:0] rd_value_c;
  logic              unused_c;

  assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Write channel: wait for both AW and W, one-cycle accept, hold response until BREADY.
  always_comb begin
    w_state_n   = w_state_q;
    wr_en_c     = 1'b0;
    wr_idx_c    = S_AXI_AWADDR[ADDR_LSB +: IDX_W];
    wr_oor_c    = |S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:HI_LSB];
    wr_store_c  = 1'b0;
    start_c     = 1'b0;
    wr_merged_c = regs_q[wr_idx_c];
    case (w_state_q)
      W_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) w_state_n = W_ACCEPT;
      W_ACCEPT: begin
        w_state_n = W_RESP;
        wr_en_c   = 1'b1;
      end
      W_RESP:   if (S_AXI_BREADY) w_state_n = W_IDLE;
      default:  w_state_n = W_IDLE;
    endcase
    for (int b = 0; b < STRB_W; b++) begin
      if (S_AXI_WSTRB[b]) wr_merged_c[b*8 +: 8] = S_AXI_WDATA[b*8 +: 8];
    end
    // Start bit is a pulse, never stored
    if (wr_idx_c == '0) wr_merged_c[0] = 1'b0;
    wr_store_c = wr_en_c && !wr_oor_c && (wr_idx_c != IDX_W'(1));
    start_c    = wr_en_c && !wr_oor_c && (wr_idx_c == '0) &&
                 S_AXI_WSTRB[0] && S_AXI_WDATA[0];
  end

  // Read channel: one-cycle accept, capture data, hold until RREADY.
  always_comb begin
    r_state_n  = r_state_q;
    rd_en_c    = 1'b0;
    rd_idx_c   = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    rd_oor_c   = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:HI_LSB];
    rd_value_c = '0;
    case (r_state_q)
      R_IDLE:   if (S_AXI_ARVALID) r_state_n = R_ACCEPT;
      R_ACCEPT: begin
        r_state_n = R_RESP;
        rd_en_c   = 1'b1;
      end
      R_RESP:   if (S_AXI_RREADY) r_state_n = R_IDLE;
      default:  r_state_n = R_IDLE;
    endcase
    if (!rd_oor_c) begin
      rd_value_c = (rd_idx_c == IDX_W'(1)) ? i_status : regs_q[rd_idx_c];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_n;
      r_state_q <= r_state_n;
    end
  end

  // Registered handshake outputs, response payloads and register storage.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      start_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      for (int k = 0; k < C_NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      awready_q <= (w_state_n == W_ACCEPT);
      bvalid_q  <= (w_state_n == W_RESP);
      start_q   <= start_c;
      arready_q <= (r_state_n == R_ACCEPT);
      rvalid_q  <= (r_state_n == R_RESP);
      if (wr_en_c)    bresp_q <= wr_oor_c ? RESP_SLVERR : RESP_OKAY;
      if (wr_store_c) regs_q[wr_idx_c] <= wr_merged_c;
      if (rd_en_c) begin
        rdata_q <= rd_value_c;
        rresp_q <= rd_oor_c ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_comb begin
    o_regs = '0;
    for (int k = 0; k < C_NUM_REGS; k++) o_regs[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign o_start       = start_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: directed AXI-Lite transactions, a cycle model checked on
// every negedge, and hand-computed literal expectations from the test plan.
module tb_axi_lite_reg_slave;

  localparam int NUM = 8;
  localparam int VW  = NUM * 32;
  localparam int TMO = 50;

  logic          aclk = 1'b0;
  logic          areset;
  logic [31:0]   awaddr, wdata, araddr, rdata, i_status;
  logic [2:0]    awprot, arprot;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, o_start;
  logic [1:0]    bresp, rresp;
  logic [VW-1:0] o_regs;

  int checks = 0;
  int errors = 0;

  axi_lite_reg_slave #(
    .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32), .C_NUM_REGS(NUM)
  ) dut (
    .S_AXI_ACLK(aclk), .S_AXI_ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready), .i_status(i_status), .o_regs(o_regs), .o_start(o_start)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of the register file and its handshake timing rules.
  logic [31:0]   m_regs [NUM];
  logic          m_on = 1'b0;
  logic          m_awready, m_bvalid, m_start, m_arready, m_rvalid;
  logic [1:0]    m_bresp, m_rresp;
  logic [31:0]   m_rdata;
  logic [VW-1:0] m_vec;
  logic          n_aw, n_ar;
  int            widx, ridx;

  always @(negedge aclk) begin
    if (m_on) begin
      for (int k = 0; k < NUM; k++) m_vec[k*32 +: 32] = m_regs[k];
      chk("m_awready", awready, m_awready);
      chk("m_wready", wready, m_awready);
      chk("m_bvalid", bvalid, m_bvalid);
      if (m_bvalid) chk("m_bresp", bresp, m_bresp);
      chk("m_arready", arready, m_arready);
      chk("m_rvalid", rvalid, m_rvalid);
      if (m_rvalid) begin
        chk("m_rdata", rdata, m_rdata);
        chk("m_rresp", rresp, m_rresp);
      end
      chk("m_start", o_start, m_start);
      chk("m_regs", o_regs, m_vec);
    end
    if (areset) begin
      for (int k = 0; k < NUM; k++) m_regs[k] = '0;
      {m_awready, m_bvalid, m_start, m_arready, m_rvalid} = '0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0;
      m_on = 1'b1;
    end else if (m_on) begin
      n_aw = awvalid && wvalid && !m_bvalid && !m_awready;
      n_ar = arvalid && !m_rvalid && !m_arready;
      // read capture sees register contents before any write completing at the same edge
      if (m_arready) begin
        ridx = int'((araddr >> 2) % NUM);
        if (araddr < 32'(NUM * 4)) begin
          m_rdata = (ridx == 1) ? i_status : m_regs[ridx];
          m_rresp = 2'b00;
        end else begin
          m_rdata = '0;
          m_rresp = 2'b10;
        end
        m_rvalid = 1'b1;
      end else if (m_rvalid && rready) begin
        m_rvalid = 1'b0;
      end
      m_start = 1'b0;
      if (m_awready) begin
        widx = int'((awaddr >> 2) % NUM);
        if (awaddr < 32'(NUM * 4)) begin
          if (widx != 1) begin
            for (int b = 0; b < 4; b++)
              if (wstrb[b]) m_regs[widx][8*b +: 8] = wdata[8*b +: 8];
            if (widx == 0) m_regs[0][0] = 1'b0;
          end
          m_start = (widx == 0) && wstrb[0] && wdata[0];
          m_bresp = 2'b00;
        end else begin
          m_bresp = 2'b10;
        end
        m_bvalid = 1'b1;
      end else if (m_bvalid && bready) begin
        m_bvalid = 1'b0;
      end
      m_awready = n_aw;
      m_arready = n_ar;
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int acc_lat, output int b_lat,
                          output logic start_at_b);
    @(posedge aclk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    acc_lat = 0;
    do begin @(posedge aclk); #1; acc_lat++; end while (!awready && acc_lat < TMO);
    if (!awready) chk("wr_accept_timeout", awready, 1);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    b_lat = acc_lat + 1;
    while (!bvalid && b_lat < TMO) begin @(posedge aclk); #1; b_lat++; end
    if (!bvalid) chk("wr_bvalid_timeout", bvalid, 1);
    resp = bresp; start_at_b = o_start;
    @(posedge aclk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int acc_lat, output int r_lat);
    @(posedge aclk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    acc_lat = 0;
    do begin @(posedge aclk); #1; acc_lat++; end while (!arready && acc_lat < TMO);
    if (!arready) chk("rd_accept_timeout", arready, 1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    r_lat = acc_lat + 1;
    while (!rvalid && r_lat < TMO) begin @(posedge aclk); #1; r_lat++; end
    if (!rvalid) chk("rd_rvalid_timeout", rvalid, 1);
    d = rdata; resp = rresp;
    @(posedge aclk); #1;
  endtask

  logic [1:0]  resp, rresp_v;
  logic [31:0] rd;
  logic        st;
  int          al, bl, ral, rl;
  logic [1:0]  resp2;
  int          al2, bl2;
  logic        st2;

  initial begin
    areset = 1'b1; awaddr = '0; wdata = '0; wstrb = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; araddr = '0; arvalid = 1'b0;
    rready = 1'b0; i_status = '0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0); chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);     chk("rst_rdata", rdata, 0);
    chk("rst_start", o_start, 0);   chk("rst_regs", o_regs, 0);

    do_write(32'h08, 32'hDEADBEEF, 4'hF, resp, al, bl, st);
    chk("w08_bresp", resp, 2'b00); chk("w08_acc_lat", al, 1); chk("w08_b_lat", bl, 2);
    chk("w08_oregs", o_regs[95:64], 32'hDEADBEEF);
    do_read(32'h08, rd, rresp_v, ral, rl);
    chk("r08_data", rd, 32'hDEADBEEF); chk("r08_rresp", rresp_v, 2'b00);
    chk("r08_acc_lat", ral, 1); chk("r08_r_lat", rl, 2);

    do_write(32'h00, 32'h00000003, 4'hF, resp, al, bl, st);
    chk("w00_start_at_b", st, 1); chk("w00_start_after", o_start, 0);
    do_read(32'h00, rd, rresp_v, ral, rl);
    chk("r00_data", rd, 32'h00000002);

    do_write(32'h0C, 32'h11223344, 4'hF, resp, al, bl, st);
    do_write(32'h0C, 32'hAABBCCDD, 4'b0101, resp, al, bl, st);
    do_read(32'h0C, rd, rresp_v, ral, rl);
    chk("r0c_strb", rd, 32'h11BB33DD);
    do_write(32'h0C, 32'hFFFFFFFF, 4'b0000, resp, al, bl, st);
    chk("w0c_nostrb_bresp", resp, 2'b00);
    do_read(32'h0C, rd, rresp_v, ral, rl);
    chk("r0c_nostrb", rd, 32'h11BB33DD);

    do_write(32'h20, 32'h12345678, 4'hF, resp, al, bl, st);
    chk("w20_bresp", resp, 2'b10); chk("w20_start", st, 0);
    chk("w20_oregs08", o_regs[95:64], 32'hDEADBEEF);
    do_read(32'h20, rd, rresp_v, ral, rl);
    chk("r20_rresp", rresp_v, 2'b10); chk("r20_rdata", rd, 0);

    i_status = 32'h5A;
    do_write(32'h04, 32'hFFFFFFFF, 4'hF, resp, al, bl, st);
    chk("w04_bresp", resp, 2'b00); chk("w04_oregs", o_regs[63:32], 0);
    do_read(32'h04, rd, rresp_v, ral, rl);
    chk("r04_status", rd, 32'h0000005A);

    // Write and read of the same register handshake at the same edge
    fork
      do_write(32'h08, 32'h12345678, 4'hF, resp2, al2, bl2, st2);
      do_read(32'h08, rd, rresp_v, ral, rl);
    join
    chk("same_edge_read_old", rd, 32'hDEADBEEF);
    do_read(32'h08, rd, rresp_v, ral, rl);
    chk("same_edge_read_new", rd, 32'h12345678);

    // AW leads W by 4 cycles; BREADY withheld with a second write pending
    @(posedge aclk); #1;
    awaddr = 32'h10; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
    bready = 1'b0;
    repeat (4) begin @(posedge aclk); #1; chk("aw_only_no_accept", awready, 0); end
    wvalid = 1'b1;
    @(posedge aclk); #1; chk("stall_accept", awready, 1);
    @(posedge aclk); #1; chk("stall_bvalid", bvalid, 1);
    awaddr = 32'h14; wdata = 32'h0BADCAFE;
    repeat (5) begin
      @(posedge aclk); #1;
      chk("hold_bvalid", bvalid, 1); chk("hold_bresp", bresp, 2'b00);
      chk("hold_no_accept", awready, 0);
    end
    bready = 1'b1;
    @(posedge aclk); #1; chk("b_done", bvalid, 0); chk("b_done_no_accept", awready, 0);
    @(posedge aclk); #1; chk("second_accept", awready, 1);
    @(posedge aclk); #1; awvalid = 1'b0; wvalid = 1'b0;
    chk("second_bvalid", bvalid, 1);
    @(posedge aclk); #1;
    do_read(32'h14, rd, rresp_v, ral, rl); chk("r14", rd, 32'h0BADCAFE);
    do_read(32'h10, rd, rresp_v, ral, rl); chk("r10", rd, 32'hCAFEF00D);

    // Reset with both responses pending
    @(posedge aclk); #1;
    awaddr = 32'h18; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b0; araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_bvalid", bvalid, 1); chk("pre_rst_rvalid", rvalid, 1);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    chk("post_rst_bvalid", bvalid, 0); chk("post_rst_rvalid", rvalid, 0);
    chk("post_rst_regs", o_regs, 0);
    bready = 1'b1; rready = 1'b1;
    repeat (5) begin
      @(posedge aclk); #1;
      chk("no_late_b", bvalid, 0); chk("no_late_r", rvalid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
